pc_gen: RTL and testbench

Parametrised fetch-PC generator for the in-order core front end. It sits between the redirect sources (trap/CLINT, EXU branch, BPU, IFU correction) and the I-cache request port. It issues sequential fetch addresses through a valid/ready handshake and latches redirects even while stalled, so none are lost. Each redirect increments an epoch that tags every request, letting downstream stages discard wrong-path responses.

---
 rtl/pc_gen.sv | 98 +++++++++
 tb/tb_pc_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// Fetch-PC generator: issues sequential I-cache fetch addresses and applies
// prioritised redirects (lowest index wins), tagging every request with an epoch.
module pc_gen #(
  parameter int              XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_ADDR   = 64'h8000_0000,
  parameter int              NRED         = 4,
  parameter int              FETCH_BYTES  = 4,
  parameter int              EPOCH_W      = 2,
  parameter int              REDIR_BUBBLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRED-1:0]      redir_valid_i,
  input  logic [NRED*XLEN-1:0] redir_pc_i,
  input  logic                 stall_i,
  output logic                 req_valid_o,
  input  logic                 req_ready_i,
  output logic [XLEN-1:0]      req_pc_o,
  output logic [EPOCH_W-1:0]   req_epoch_o,
  output logic                 redir_taken_o,
  output logic [31:0]          redir_cnt_o
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  state_t              state_r;
  logic [XLEN-1:0]     pc_r;
  logic [EPOCH_W-1:0]  epoch_r;
  logic                taken_r;
  logic [31:0]         cnt_r;

  logic                redir_s;
  logic [XLEN-1:0]     target_s;
  logic                fire_s;

  // Redirect arbitration: scan from the top so the lowest set index ends up selected.
  always_comb begin
    redir_s  = |redir_valid_i;
    target_s = {XLEN{1'b0}};
    for (int k = NRED - 1; k >= 0; k--) begin
      if (redir_valid_i[k]) begin
        target_s = redir_pc_i[k*XLEN +: XLEN];
      end else begin
        target_s = target_s;
      end
    end
    target_s[0] = 1'b0;
  end

  assign req_valid_o = (state_r == RUN) & ~stall_i;
  assign fire_s      = req_valid_o & req_ready_i;

  // PC, epoch, state and redirect bookkeeping; a redirect overrides any same-cycle fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= BOOT;
      pc_r    <= RESET_ADDR;
      epoch_r <= {EPOCH_W{1'b0}};
      taken_r <= 1'b0;
      cnt_r   <= 32'd0;
    end else begin
      taken_r <= redir_s;
      if (redir_s) begin
        pc_r    <= target_s;
        epoch_r <= epoch_r + EPOCH_W'(1);
        state_r <= (REDIR_BUBBLE != 0) ? BUBBLE : RUN;
        if (cnt_r != 32'hFFFF_FFFF) begin
          cnt_r <= cnt_r + 32'd1;
        end else begin
          cnt_r <= cnt_r;
        end
      end else begin
        case (state_r)
          BOOT:    state_r <= RUN;
          RUN: begin
            if (fire_s) begin
              pc_r <= pc_r + XLEN'(FETCH_BYTES);
            end else begin
              pc_r <= pc_r;
            end
          end
          BUBBLE:  state_r <= RUN;
          default: state_r <= BOOT;
        endcase
      end
    end
  end

  assign req_pc_o      = pc_r;
  assign req_epoch_o   = epoch_r;
  assign redir_taken_o = taken_r;
  assign redir_cnt_o   = cnt_r;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus random traffic,
// compared each cycle against a cycle-level behavioural model.
module tb_pc_gen;
  localparam int          XLEN   = 64;
  localparam int          NRED   = 4;
  localparam int          FB     = 4;
  localparam int          EW     = 2;
  localparam int          RB     = 1;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NRED-1:0]      redir_valid;
  logic [NRED*XLEN-1:0] redir_pc;
  logic                 stall;
  logic                 req_ready;
  logic                 req_valid;
  logic [XLEN-1:0]      req_pc;
  logic [EW-1:0]        req_epoch;
  logic                 redir_taken;
  logic [31:0]          redir_cnt;

  int checks = 0;
  int errors = 0;

  // Model: number of idle cycles still owed before requests may issue, plus architectural values.
  logic [63:0] m_pc;
  int          m_idle;
  int          m_epoch;
  longint      m_cnt;
  logic        m_taken;

  always #5 clk = ~clk;

  pc_gen #(.XLEN(XLEN), .RESET_ADDR(RST_PC), .NRED(NRED), .FETCH_BYTES(FB),
           .EPOCH_W(EW), .REDIR_BUBBLE(RB)) dut (
    .clk(clk), .rst(rst), .redir_valid_i(redir_valid), .redir_pc_i(redir_pc),
    .stall_i(stall), .req_valid_o(req_valid), .req_ready_i(req_ready),
    .req_pc_o(req_pc), .req_epoch_o(req_epoch), .redir_taken_o(redir_taken),
    .redir_cnt_o(redir_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_idle = 1; m_epoch = 0; m_cnt = 0; m_taken = 1'b0;
  endtask

  function automatic logic [63:0] pick_target(input logic [3:0] rv, input logic [255:0] rpc);
    for (int k = 0; k < 4; k++)
      if (rv[k]) return rpc[k*64 +: 64] & ~64'd1;
    return 64'd0;
  endfunction

  // Drive at the falling edge, check 1ns later, advance the model, wait one full cycle.
  task automatic cyc(input logic [3:0] rv, input logic [255:0] rpc, input logic st, input logic rdy);
    logic mv;
    redir_valid = rv; redir_pc = rpc; stall = st; req_ready = rdy;
    #1;
    mv = (m_idle == 0) && !st;
    chk("valid", {63'd0, req_valid}, {63'd0, mv});
    chk("pc", req_pc, m_pc);
    chk("epoch", {62'd0, req_epoch}, 64'(m_epoch));
    chk("taken", {63'd0, redir_taken}, {63'd0, m_taken});
    chk("cnt", {32'd0, redir_cnt}, 64'(m_cnt));
    if (rv != 4'd0) begin
      m_pc    = pick_target(rv, rpc);
      m_epoch = (m_epoch + 1) % (1 << EW);
      m_cnt   = (m_cnt < 64'hFFFF_FFFF) ? m_cnt + 1 : m_cnt;
      m_idle  = RB;
      m_taken = 1'b1;
    end else begin
      m_taken = 1'b0;
      if (m_idle > 0) m_idle--;
      else if (mv && rdy) m_pc = m_pc + 64'(FB);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_valid"}, {63'd0, req_valid}, 64'd0);
    chk({tag, "_pc"}, req_pc, RST_PC);
    chk({tag, "_epoch"}, {62'd0, req_epoch}, 64'd0);
    chk({tag, "_taken"}, {63'd0, redir_taken}, 64'd0);
    chk({tag, "_cnt"}, {32'd0, redir_cnt}, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; redir_valid = '0; redir_pc = '0; stall = 1'b0; req_ready = 1'b0;
    @(negedge clk);
    check_reset_values("rst");
    model_reset();
    rst = 1'b0;
  endtask

  logic [255:0] t;

  initial begin
    do_reset();

    // Boot cycle then four sequential fetches.
    t = '0;
    cyc(4'b0000, t, 1'b0, 1'b1);
    chk("seq_first_pc", req_pc, 64'h8000_0000);
    for (int i = 0; i < 4; i++) cyc(4'b0000, t, 1'b0, 1'b1);
    chk("seq_pc4", req_pc, 64'h8000_0010);

    // Branch and BPU together: branch (index 1) wins.
    t[64 +: 64] = 64'h8000_1000; t[128 +: 64] = 64'h8000_2000;
    cyc(4'b0110, t, 1'b0, 1'b1);
    #1;
    chk("redir_pc", req_pc, 64'h8000_1000);
    chk("redir_valid_bubble", {63'd0, req_valid}, 64'd0);
    chk("redir_epoch", {62'd0, req_epoch}, 64'd1);
    cyc(4'b0000, t, 1'b0, 1'b1);
    cyc(4'b0000, t, 1'b0, 1'b1);

    // Five-cycle stall with a trap redirect in the second stalled cycle.
    t = '0; t[0 +: 64] = 64'h8000_0100;
    cyc(4'b0000, t, 1'b1, 1'b1);
    cyc(4'b0001, t, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc(4'b0000, t, 1'b1, 1'b1);
    chk("stall_pc", req_pc, 64'h8000_0100);
    cyc(4'b0000, t, 1'b0, 1'b1);
    cyc(4'b0000, t, 1'b0, 1'b1);

    // Ready held low: PC and epoch stable, then a single increment.
    for (int i = 0; i < 3; i++) cyc(4'b0000, t, 1'b0, 1'b0);
    cyc(4'b0000, t, 1'b0, 1'b1);
    cyc(4'b0000, t, 1'b0, 1'b0);

    // Five back-to-back redirects from a fresh reset, then top-of-space wrap.
    do_reset();
    cyc(4'b0000, t, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      t = '0; t[128 +: 64] = 64'h9000_0000 + 64'(i * 16);
      cyc(4'b0100, t, 1'b0, 1'b1);
    end
    #1;
    chk("five_epoch", {62'd0, req_epoch}, 64'd1);
    chk("five_cnt", {32'd0, redir_cnt}, 64'd5);
    t = '0; t[192 +: 64] = 64'hFFFF_FFFF_FFFF_FFFC;
    cyc(4'b1000, t, 1'b0, 1'b1);
    cyc(4'b0000, t, 1'b0, 1'b1);
    cyc(4'b0000, t, 1'b0, 1'b1);
    chk("wrap_pc", req_pc, 64'd0);

    // Redirect during the boot cycle, with an odd target.
    do_reset();
    t = '0; t[64 +: 64] = 64'h8000_3001;
    cyc(4'b0010, t, 1'b0, 1'b1);
    cyc(4'b0000, t, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) cyc(4'b0000, t, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] rv;
      for (int k = 0; k < 4; k++) t[k*64 +: 64] = {$urandom, $urandom};
      rv = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
      cyc(rv, t, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
    end

    // Asynchronous reset in the middle of a stalled handshake.
    cyc(4'b0000, t, 1'b0, 1'b0);
    cyc(4'b0000, t, 1'b0, 1'b0);
    redir_valid = '0; stall = 1'b0; req_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    t = '0;
    for (int i = 0; i < 4; i++) cyc(4'b0000, t, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
